// File: rtl/conv_sched_pkg.sv
// Shared types and default geometry for the TDM slot scheduler.
package conv_sched_pkg;

    localparam int SLOTS_DEF         = 32;
    localparam int BITS_PER_SLOT_DEF = 8;
    localparam int FRAME_BITS_DEF    = SLOTS_DEF * BITS_PER_SLOT_DEF;
    localparam int SLOT_W_DEF        = $clog2(SLOTS_DEF);
    localparam int BIT_W_DEF         = $clog2(BITS_PER_SLOT_DEF);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DT   = 2'd1,
        OWN_STM  = 2'd2,
        OWN_RSVD = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } sched_state_e;

    // Reserved owner codes behave exactly like an unowned slot.
    function automatic logic owner_is_free(input owner_e own);
        return (own == OWN_NONE) || (own == OWN_RSVD);
    endfunction

endpackage

// File: rtl/conv_edge_sync.sv
// Multi-flop synchroniser with a registered output: either a rising-edge pulse
// (EDGE_DET=1) or the synchronised level delayed to the same latency (EDGE_DET=0).
module conv_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_DET    = 1'b1,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_q;
    logic                   out_q;
    logic                   out_d;

    always_comb begin
        out_d = sync_q[SYNC_STAGES-1];
        if (EDGE_DET) begin
            out_d = sync_q[SYNC_STAGES-1] & ~lvl_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            lvl_q  <= RESET_VAL;
            out_q  <= EDGE_DET ? 1'b0 : RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            lvl_q  <= sync_q[SYNC_STAGES-1];
            out_q  <= out_d;
        end
    end

    assign sync_o = out_q;

endmodule

// File: rtl/conv_tdm_slot_scheduler.sv
// ST-BUS style frame/slot sequencer: locks to f0, tracks slot/bit, grants bits from an owner table.
// Optional test pattern on unowned slots when CONV_SCHED_TEST_PAT_EN is defined.
module conv_tdm_slot_scheduler
    import conv_sched_pkg::*;
#(
    parameter int SLOTS         = SLOTS_DEF,
    parameter int BITS_PER_SLOT = BITS_PER_SLOT_DEF,
    parameter int SYNC_STAGES   = 2,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic                             clk50,
    input  logic                             reset_n,
    input  logic                             c4,
    input  logic                             f0,
    input  logic                             cfg_we,
    input  logic [$clog2(SLOTS)-1:0]         cfg_slot,
    input  logic [1:0]                       cfg_owner,
    input  logic                             cpu_ack,
    input  logic                             err_clr,
    output logic                             bit_strobe,
    output logic [$clog2(SLOTS)-1:0]         slot_idx,
    output logic [$clog2(BITS_PER_SLOT)-1:0] bit_idx,
    output logic                             grant_dt,
    output logic                             grant_stm,
    output logic                             locked,
    output logic                             sync_err,
    output logic                             cpu_int,
    output logic                             test_out
);

    localparam int SLOT_W = $clog2(SLOTS);
    localparam int BIT_W  = $clog2(BITS_PER_SLOT);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

    logic              strobe_w;
    logic              f0_s;
    sched_state_e      state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    owner_e            owner_q [SLOTS];
    owner_e            own_cur;
    logic              at_end, loss, frame_hit;
    logic              grant_dt_q, grant_stm_q, sync_err_q, cpu_int_q;

    conv_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1), .RESET_VAL(1'b0)) u_c4_sync (
        .clk_i(clk50), .rst_n_i(reset_n), .d_i(c4), .sync_o(strobe_w)
    );

    // f0 is active low, so its synchroniser idles high out of reset.
    conv_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0), .RESET_VAL(1'b1)) u_f0_sync (
        .clk_i(clk50), .rst_n_i(reset_n), .d_i(f0), .sync_o(f0_s)
    );

    assign at_end = (slot_q == SLOT_W'(SLOTS - 1)) && (bit_q == BIT_W'(BITS_PER_SLOT - 1));

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        loss      = 1'b0;
        frame_hit = 1'b0;
        if (strobe_w) begin
            case (state_q)
                ST_HUNT: begin
                    if (!f0_s) begin
                        state_d = ST_ALIGN;
                        good_d  = '0;
                    end
                end
                ST_ALIGN: begin
                    if (!f0_s && at_end) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_q == GOOD_W'(LOCK_FRAMES - 1)) state_d = ST_LOCKED;
                    end else if (!f0_s) begin
                        good_d = '0;
                    end else if (at_end) begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // Pulse missing at the frame boundary or arriving anywhere else.
                    if (f0_s == at_end) begin
                        state_d = ST_HUNT;
                        loss    = 1'b1;
                    end else if (at_end) begin
                        frame_hit = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        slot_d = slot_q;
        bit_d  = bit_q;
        if (strobe_w) begin
            if (!f0_s || at_end) begin
                slot_d = '0;
                bit_d  = '0;
            end else if (bit_q == BIT_W'(BITS_PER_SLOT - 1)) begin
                slot_d = slot_q + SLOT_W'(1);
                bit_d  = '0;
            end else begin
                bit_d = bit_q + BIT_W'(1);
            end
        end
    end

    assign own_cur = (cfg_we && (cfg_slot == slot_d)) ? owner_e'(cfg_owner) : owner_q[slot_d];

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            slot_q      <= '0;
            bit_q       <= '0;
            grant_dt_q  <= 1'b0;
            grant_stm_q <= 1'b0;
            sync_err_q  <= 1'b0;
            cpu_int_q   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) owner_q[i] <= OWN_NONE;
        end else begin
            slot_q     <= slot_d;
            bit_q      <= bit_d;
            sync_err_q <= loss | (sync_err_q & ~err_clr);
            cpu_int_q  <= frame_hit | (cpu_int_q & ~cpu_ack);
            if (cfg_we) owner_q[cfg_slot] <= owner_e'(cfg_owner);
            if (strobe_w) begin
                grant_dt_q  <= (state_d == ST_LOCKED) && (own_cur == OWN_DT);
                grant_stm_q <= (state_d == ST_LOCKED) && (own_cur == OWN_STM);
            end
        end
    end

`ifdef CONV_SCHED_TEST_PAT_EN
    logic test_q;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            test_q <= 1'b0;
        end else if (strobe_w) begin
            test_q <= (state_d == ST_LOCKED) && owner_is_free(own_cur) && !bit_d[0];
        end
    end

    assign test_out = test_q;
`else
    assign test_out = 1'b0;
`endif

    always_comb begin
        bit_strobe = strobe_w;
        slot_idx   = slot_q;
        bit_idx    = bit_q;
        locked     = (state_q == ST_LOCKED);
        grant_dt   = grant_dt_q;
        grant_stm  = grant_stm_q;
        sync_err   = sync_err_q;
        cpu_int    = cpu_int_q;
    end

endmodule
